// File: rtl/sha1_core.sv
// sha1_core: single-block SHA-1 compression engine.
// One 512-bit pre-padded block is compressed per start. The chaining value
// H0..H4 persists across blocks, so a multi-block message is hashed by feeding
// its blocks in order after one reset.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset; restores the IV and clears done
//   feed     block-start request; a low-to-high transition seen in IDLE starts
//   message  padded block, message[511:480] = W0
//   hash     {H0,H1,H2,H3,H4}, driven directly from the H registers
//   done     high once the last accepted block has been folded into H
module sha1_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         feed,
  input  logic [511:0] message,
  output logic [159:0] hash,
  output logic         done
);

  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hEFCDAB89;
  localparam logic [31:0] IV2 = 32'h98BADCFE;
  localparam logic [31:0] IV3 = 32'h10325476;
  localparam logic [31:0] IV4 = 32'hC3D2E1F0;
  localparam logic [31:0] K0  = 32'h5A827999;
  localparam logic [31:0] K1  = 32'h6ED9EBA1;
  localparam logic [31:0] K2  = 32'h8F1BBCDC;
  localparam logic [31:0] K3  = 32'hCA62C1D6;

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [6:0]  t_q, t_d;
  logic        done_q, done_d;
  logic        feed_prev_q, feed_prev_d;
  logic [31:0] h0_q, h1_q, h2_q, h3_q, h4_q;
  logic [31:0] h0_d, h1_d, h2_d, h3_d, h4_d;
  logic [31:0] a_q, b_q, c_q, d_q, e_q;
  logic [31:0] a_d, b_d, c_d, d_d, e_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic        start;
  logic [31:0] tmp;
  logic [31:0] w_new;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

  function automatic logic [31:0] f_func(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] k_func(input logic [6:0] t);
    if (t < 7'd20)      return K0;
    else if (t < 7'd40) return K1;
    else if (t < 7'd60) return K2;
    else                return K3;
  endfunction

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    done_d      = done_q;
    feed_prev_d = feed;
    h0_d = h0_q; h1_d = h1_q; h2_d = h2_q; h3_d = h3_q; h4_d = h4_q;
    a_d  = a_q;  b_d  = b_q;  c_d  = c_q;  d_d  = d_q;  e_d  = e_q;
    w_d  = w_q;
    start = (state_q == IDLE) && feed && !feed_prev_q;
    // w_q[0] always holds W[t]; the window slides one word per round.
    tmp   = rotl5(a_q) + f_func(t_q, b_q, c_q, d_q) + e_q + k_func(t_q) + w_q[0];
    w_new = rotl1(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0]);

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < 16; i++) w_d[i] = message[511 - 32*i -: 32];
          a_d = h0_q; b_d = h1_q; c_d = h2_q; d_d = h3_q; e_d = h4_q;
          t_d     = 7'd0;
          done_d  = 1'b0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        e_d = d_q;
        d_d = c_q;
        c_d = rotl30(b_q);
        b_d = a_q;
        a_d = tmp;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        t_d = t_q + 7'd1;
        if (t_q == 7'd79) state_d = FINAL;
      end
      FINAL: begin
        h0_d = h0_q + a_q;
        h1_d = h1_q + b_q;
        h2_d = h2_q + c_q;
        h3_d = h3_q + d_q;
        h4_d = h4_q + e_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and chaining state: cleared / reloaded with the IV on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      t_q         <= 7'd0;
      done_q      <= 1'b0;
      feed_prev_q <= 1'b0;
      h0_q <= IV0; h1_q <= IV1; h2_q <= IV2; h3_q <= IV3; h4_q <= IV4;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      done_q      <= done_d;
      feed_prev_q <= feed_prev_d;
      h0_q <= h0_d; h1_q <= h1_d; h2_q <= h2_d; h3_q <= h3_d; h4_q <= h4_d;
    end
  end

  // Working variables and schedule window are always loaded before use.
  always_ff @(posedge clk) begin
    a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; e_q <= e_d;
    w_q <= w_d;
  end

  assign hash = {h0_q, h1_q, h2_q, h3_q, h4_q};
  assign done = done_q;

endmodule

// File: tb/tb_sha1_core.sv
module tb_sha1_core;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         feed;
  logic [511:0] message;
  logic [159:0] hash;
  logic         done;

  int checks = 0;
  int fails  = 0;

  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  byte unsigned msg_bytes[$];
  logic [511:0] blk_q[$];

  sha1_core dut (
    .clk     (clk),
    .reset   (reset_n),
    .feed    (feed),
    .message (message),
    .hash    (hash),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference SHA-1 compression with a full 80-word message schedule.
  function automatic logic [159:0] ref_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp, x;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {x[30:0], x[31]};
    end
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Pad msg_bytes into 512-bit blocks in blk_q.
  function automatic void make_blocks();
    byte unsigned bytes[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    bytes  = msg_bytes;
    bitlen = 64'(msg_bytes.size()) * 64'd8;
    bytes.push_back(8'h80);
    while (bytes.size() % 64 != 56) bytes.push_back(8'h00);
    for (int i = 7; i >= 0; i--) bytes.push_back(bitlen[8*i +: 8]);
    blk_q.delete();
    for (int b = 0; b < bytes.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = bytes[64*b + j];
      blk_q.push_back(blk);
    end
  endfunction

  function automatic void load_string(input string s);
    msg_bytes.delete();
    for (int i = 0; i < s.len(); i++) msg_bytes.push_back(s[i]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    feed    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Starts one block and measures the edge count until done, counting the
  // accept edge as 1. fell reports done low right after the accept edge.
  task automatic send_block(input logic [511:0] blk, output int lat, output logic fell);
    @(negedge clk);
    message = blk;
    feed    = 1'b1;
    @(posedge clk);
    #1;
    fell = (done === 1'b0);
    lat  = 1;
    @(negedge clk);
    feed = 1'b0;
    for (int i = 0; i < 16; i++) message[32*i +: 32] = $urandom;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    feed    = 1'b0;
    message = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (hash !== IV) begin
      fails++;
      $display("FAIL reset_hash: got %h expected %h", hash, IV);
    end
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    string        strs [3];
    logic [159:0] digs [3];
    logic [159:0] ref_h;
    int           lat;
    logic         fell;
    strs[0] = "abc";
    digs[0] = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    strs[1] = "Hello, world!";
    digs[1] = 160'h943a702d06f34599aee1f8da8ef9f7296031d699;
    strs[2] = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    digs[2] = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
    for (int v = 0; v < 3; v++) begin
      do_reset();
      load_string(strs[v]);
      make_blocks();
      ref_h = IV;
      for (int b = 0; b < blk_q.size(); b++) begin
        ref_h = ref_compress(ref_h, blk_q[b]);
        send_block(blk_q[b], lat, fell);
        checks++;
        if (lat != 82) begin
          fails++;
          $display("FAIL kat%0d_latency blk%0d: got %0d expected 82", v, b, lat);
        end
        checks++;
        if (!fell) begin
          fails++;
          $display("FAIL kat%0d_done_fall blk%0d: done not low after start", v, b);
        end
        checks++;
        if (hash !== ref_h) begin
          fails++;
          $display("FAIL kat%0d_chain blk%0d: got %h expected %h", v, b, hash, ref_h);
        end
      end
      checks++;
      if (hash !== digs[v] || done !== 1'b1) begin
        fails++;
        $display("FAIL kat%0d_digest: got %h done=%b expected %h done=1", v, hash, done, digs[v]);
      end
    end
  endtask

  task automatic test_random_multiblock();
    int           lens [3];
    logic [159:0] ref_h;
    int           lat;
    logic         fell;
    lens[0] = 64; lens[1] = 67; lens[2] = 128;
    for (int v = 0; v < 3; v++) begin
      do_reset();
      msg_bytes.delete();
      for (int i = 0; i < lens[v]; i++) msg_bytes.push_back(8'($urandom_range(32, 126)));
      make_blocks();
      ref_h = IV;
      for (int b = 0; b < blk_q.size(); b++) begin
        ref_h = ref_compress(ref_h, blk_q[b]);
        send_block(blk_q[b], lat, fell);
        checks++;
        if (lat != 82 || !fell) begin
          fails++;
          $display("FAIL rand%0d_timing blk%0d: latency %0d fell=%b expected 82 fell=1", lens[v], b, lat, fell);
        end
        checks++;
        if (hash !== ref_h) begin
          fails++;
          $display("FAIL rand%0d_hash blk%0d: got %h expected %h", lens[v], b, hash, ref_h);
        end
      end
    end
  endtask

  task automatic test_feed_hold();
    logic [511:0] blk;
    logic [159:0] ref_h;
    int           lat;
    do_reset();
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
    ref_h = ref_compress(IV, blk);
    @(negedge clk);
    message = blk;
    feed    = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    // feed high for 10 edges, low for one, then a second rise during ROUND
    // that stays high well past the end of the block.
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      feed = (lat == 10) ? 1'b0 : 1'b1;
      if (lat == 2) message = ~blk;
      @(posedge clk);
      lat++;
      #1;
    end
    checks++;
    if (lat != 82) begin
      fails++;
      $display("FAIL hold_latency: got %0d expected 82", lat);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (done !== 1'b1 || hash !== ref_h) begin
      fails++;
      $display("FAIL hold_single_block: hash %h done=%b expected %h done=1", hash, done, ref_h);
    end
    feed = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || hash !== ref_h) begin
      fails++;
      $display("FAIL hold_feed_fall: hash %h done=%b expected %h done=1", hash, done, ref_h);
    end
    // After feed has returned low a fresh edge starts again, chaining from H.
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
    ref_h = ref_compress(ref_h, blk);
    @(negedge clk);
    message = blk;
    feed    = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL hold_rearm_start: done %b expected 0", done);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
    feed = 1'b0;
    checks++;
    if (lat != 82 || hash !== ref_h) begin
      fails++;
      $display("FAIL hold_rearm_block: latency %0d hash %h expected 82 %h", lat, hash, ref_h);
    end
  endtask

  task automatic test_reset_abort();
    logic [511:0] blk;
    int           lat;
    logic         fell;
    do_reset();
    load_string("abc");
    make_blocks();
    blk = blk_q[0];
    @(negedge clk);
    message = blk;
    feed    = 1'b1;
    repeat (41) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (hash !== IV || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_async: hash %h done=%b expected %h done=0", hash, done, IV);
    end
    feed = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (hash !== IV || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_release: hash %h done=%b expected %h done=0", hash, done, IV);
    end
    send_block(blk, lat, fell);
    checks++;
    if (hash !== 160'ha9993e364706816aba3e25717850c26c9cd0d89d || lat != 82) begin
      fails++;
      $display("FAIL abort_then_abc: hash %h latency %0d expected a9993e364706816aba3e25717850c26c9cd0d89d 82", hash, lat);
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_multiblock();
    test_feed_hold();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
